// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types and constants for the control-flow redirect sequencer.
package branch_ctrl_pkg;

    localparam int unsigned PC_W_DEF  = 9;
    localparam int unsigned CNT_W_DEF = 32;
    localparam int unsigned BRPC_W    = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_SHADOW  = 2'd2
    } state_e;

    // Word-aligned targets have both low address bits clear.
    function automatic logic target_misaligned(input logic [1:0] lo_bits);
        return |lo_bits;
    endfunction

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// EX-side decision inputs and PC/flush control outputs of the redirect sequencer.
interface branch_redirect_ctrl_if
    import branch_ctrl_pkg::*;
#(
    parameter int unsigned PC_W  = PC_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
);
    logic                ex_valid;
    logic                ex_is_cf;
    logic                ex_pcsel;
    logic [BRPC_W-1:0]   ex_brpc;
    logic                stall_in;
    logic                freeze;

    logic                pc_sel;
    logic [PC_W-1:0]     pc_target;
    logic                pc_we;
    logic                flush_ifid;
    logic                flush_idex;
    logic                redirect_busy;
    logic                misalign;
    logic [CNT_W-1:0]    cnt_branch;
    logic [CNT_W-1:0]    cnt_taken;

    // Pipeline side: drives the EX decision and hazard inputs.
    modport master (
        output ex_valid, ex_is_cf, ex_pcsel, ex_brpc, stall_in, freeze,
        input  pc_sel, pc_target, pc_we, flush_ifid, flush_idex,
               redirect_busy, misalign, cnt_branch, cnt_taken
    );

    // Sequencer side.
    modport slave (
        input  ex_valid, ex_is_cf, ex_pcsel, ex_brpc, stall_in, freeze,
        output pc_sel, pc_target, pc_we, flush_ifid, flush_idex,
               redirect_busy, misalign, cnt_branch, cnt_taken
    );

endinterface

// File: rtl/branch_redirect_ctrl_perf_counter.sv
// Wrapping event counter with increment enable and synchronous reset.
module br_perf_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Sequences EX-stage redirects into PC mux/write-enable and pipeline flushes,
// deferring across freezes and masking the flushed shadow slot.
module branch_redirect_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int unsigned PC_W  = PC_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    branch_redirect_ctrl_if.slave bus
);

    state_e          state_q;
    state_e          state_d;
    logic [PC_W-1:0] pend_q;
    logic [PC_W-1:0] pend_d;

    logic            take_c;
    logic            issue_c;
    logic [PC_W-1:0] issue_tgt_c;
    logic            busy_c;
    logic            cnt_br_inc_c;

    // Only the low PC_W target bits reach the PC register.
    logic            unused_brpc_hi;
    assign unused_brpc_hi = ^bus.ex_brpc[BRPC_W-1:PC_W];

    assign take_c = bus.ex_valid & bus.ex_pcsel;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        issue_c      = 1'b0;
        issue_tgt_c  = '0;
        busy_c       = 1'b0;
        cnt_br_inc_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // A frozen not-taken branch waits for the freeze to drop before it counts.
                cnt_br_inc_c = bus.ex_valid & bus.ex_is_cf & (~bus.freeze | bus.ex_pcsel);
                if (take_c) begin
                    if (bus.freeze) begin
                        pend_d  = bus.ex_brpc[PC_W-1:0];
                        state_d = ST_PENDING;
                    end else begin
                        issue_c     = 1'b1;
                        issue_tgt_c = bus.ex_brpc[PC_W-1:0];
                        state_d     = ST_SHADOW;
                    end
                end
            end
            ST_PENDING: begin
                busy_c = 1'b1;
                if (!bus.freeze) begin
                    issue_c     = 1'b1;
                    issue_tgt_c = pend_q;
                    state_d     = ST_SHADOW;
                end
            end
            ST_SHADOW: begin
                if (!bus.freeze) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (reset) begin
            state_d      = ST_IDLE;
            pend_d       = '0;
            issue_c      = 1'b0;
            issue_tgt_c  = '0;
            busy_c       = 1'b0;
            cnt_br_inc_c = 1'b0;
        end
    end

    // Redirect outputs are combinational so a taken branch redirects in its own cycle.
    always_comb begin
        bus.pc_sel        = issue_c;
        bus.pc_target     = issue_tgt_c;
        bus.flush_ifid    = issue_c;
        bus.flush_idex    = issue_c;
        bus.redirect_busy = busy_c;
        bus.misalign      = issue_c & target_misaligned(issue_tgt_c[1:0]);
        bus.pc_we         = 1'b0;
        if (!reset) begin
            bus.pc_we = issue_c | (~bus.stall_in & ~bus.freeze);
        end
    end

    br_perf_counter #(.CNT_W(CNT_W)) u_cnt_branch (
        .clk   (clk),
        .reset (reset),
        .inc_i (cnt_br_inc_c),
        .cnt_o (bus.cnt_branch)
    );

    br_perf_counter #(.CNT_W(CNT_W)) u_cnt_taken (
        .clk   (clk),
        .reset (reset),
        .inc_i (issue_c),
        .cnt_o (bus.cnt_taken)
    );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Randomized bench for branch_redirect_ctrl against a queue-based redirect model.
module tb_branch_redirect_ctrl;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    branch_redirect_ctrl_if #(.PC_W(9), .CNT_W(32)) bi ();
    branch_redirect_ctrl_if #(.PC_W(9), .CNT_W(4))  bs ();

    assign bs.ex_valid = bi.ex_valid;
    assign bs.ex_is_cf = bi.ex_is_cf;
    assign bs.ex_pcsel = bi.ex_pcsel;
    assign bs.ex_brpc  = bi.ex_brpc;
    assign bs.stall_in = bi.stall_in;
    assign bs.freeze   = bi.freeze;

    branch_redirect_ctrl #(.PC_W(9), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bi)
    );

    branch_redirect_ctrl #(.PC_W(9), .CNT_W(4)) dut_small (
        .clk   (clk),
        .reset (reset),
        .bus   (bs)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a redirect waiting out a freeze, whether the shadow slot is live, event totals.
    logic [8:0]  held_m[$];
    bit          shadow_m = 1'b0;
    int unsigned branches_m = 0;
    int unsigned takens_m   = 0;

    always @(negedge clk) begin
        bit          e_issue;
        bit          e_busy;
        bit          e_we;
        logic [8:0]  e_tgt;
        bit          take;
        bit          idle;

        take    = bi.ex_valid && bi.ex_pcsel;
        idle    = (held_m.size() == 0) && !shadow_m;
        e_issue = 1'b0;
        e_busy  = 1'b0;
        e_tgt   = 9'd0;
        if (!reset) begin
            if (held_m.size() != 0) begin
                e_busy = 1'b1;
                if (!bi.freeze) begin
                    e_issue = 1'b1;
                    e_tgt   = held_m[0];
                end
            end else if (!shadow_m && take && !bi.freeze) begin
                e_issue = 1'b1;
                e_tgt   = bi.ex_brpc[8:0];
            end
        end
        e_we = !reset && (e_issue || (!bi.stall_in && !bi.freeze));

        chk("pc_sel", 32'(bi.pc_sel), 32'(e_issue));
        chk("pc_we", 32'(bi.pc_we), 32'(e_we));
        chk("flush_ifid", 32'(bi.flush_ifid), 32'(e_issue));
        chk("flush_idex", 32'(bi.flush_idex), 32'(e_issue));
        chk("redirect_busy", 32'(bi.redirect_busy), 32'(e_busy));
        chk("misalign", 32'(bi.misalign), 32'(e_issue && (e_tgt[1:0] != 2'b00)));
        if (e_issue || reset) begin
            chk("pc_target", 32'(bi.pc_target), 32'(e_tgt));
            chk("small_pc_target", 32'(bs.pc_target), 32'(e_tgt));
        end
        chk("cnt_branch", bi.cnt_branch, branches_m);
        chk("cnt_taken", bi.cnt_taken, takens_m);
        chk("small_cnt_branch", 32'(bs.cnt_branch), branches_m & 32'hF);
        chk("small_cnt_taken", 32'(bs.cnt_taken), takens_m & 32'hF);
        chk("small_pc_sel", 32'(bs.pc_sel), 32'(e_issue));

        // Advance the model to the state after the coming rising edge.
        if (reset) begin
            held_m.delete();
            shadow_m   = 1'b0;
            branches_m = 0;
            takens_m   = 0;
        end else begin
            if (idle && bi.ex_valid && bi.ex_is_cf && (!bi.freeze || bi.ex_pcsel))
                branches_m++;
            if (e_issue)
                takens_m++;
            if (held_m.size() != 0) begin
                if (!bi.freeze) begin
                    void'(held_m.pop_front());
                    shadow_m = 1'b1;
                end
            end else if (shadow_m) begin
                if (!bi.freeze) shadow_m = 1'b0;
            end else if (take) begin
                if (bi.freeze) held_m.push_back(bi.ex_brpc[8:0]);
                else           shadow_m = 1'b1;
            end
        end
    end

    task automatic drive(input bit rst, input bit v, input bit cf, input bit ps,
                         input logic [31:0] tgt, input bit st, input bit fz);
        @(posedge clk);
        #1;
        reset       = rst;
        bi.ex_valid = v;
        bi.ex_is_cf = cf;
        bi.ex_pcsel = ps;
        bi.ex_brpc  = tgt;
        bi.stall_in = st;
        bi.freeze   = fz;
        @(negedge clk);
    endtask

    initial begin
        reset       = 1'b1;
        bi.ex_valid = 1'b0;
        bi.ex_is_cf = 1'b0;
        bi.ex_pcsel = 1'b0;
        bi.ex_brpc  = 32'd0;
        bi.stall_in = 1'b0;
        bi.freeze   = 1'b0;

        // Reset dominates a taken branch.
        drive(1, 1, 1, 1, 32'h44, 0, 0);
        chk("rst_pc_sel", 32'(bi.pc_sel), 32'd0);
        chk("rst_pc_we", 32'(bi.pc_we), 32'd0);
        chk("rst_pc_target", 32'(bi.pc_target), 32'd0);

        // Taken branch to 0x40, then the shadow slot repeats the decision.
        drive(0, 1, 1, 1, 32'h40, 0, 0);
        chk("t1_pc_sel", 32'(bi.pc_sel), 32'd1);
        chk("t1_pc_target", 32'(bi.pc_target), 32'h40);
        chk("t1_flushes", {30'd0, bi.flush_ifid, bi.flush_idex}, 32'd3);
        drive(0, 1, 1, 1, 32'h40, 0, 0);
        chk("t1_shadow_sel", 32'(bi.pc_sel), 32'd0);
        drive(0, 0, 0, 0, 32'h0, 0, 0);
        chk("t1_cnt_taken", bi.cnt_taken, 32'd1);
        chk("t1_cnt_branch", bi.cnt_branch, 32'd1);

        // Taken under a three-cycle freeze.
        drive(1, 0, 0, 0, 32'h0, 0, 0);
        drive(0, 1, 1, 1, 32'h80, 0, 1);
        chk("t2_busy0", 32'(bi.redirect_busy), 32'd0);
        drive(0, 1, 1, 1, 32'h80, 0, 1);
        chk("t2_busy1", 32'(bi.redirect_busy), 32'd1);
        drive(0, 1, 1, 1, 32'h80, 0, 1);
        chk("t2_busy2", 32'(bi.redirect_busy), 32'd1);
        chk("t2_no_sel", 32'(bi.pc_sel), 32'd0);
        drive(0, 0, 0, 0, 32'h0, 0, 0);
        chk("t2_busy3", 32'(bi.redirect_busy), 32'd1);
        chk("t2_pc_target", 32'(bi.pc_target), 32'h80);
        chk("t2_pc_sel", 32'(bi.pc_sel), 32'd1);
        drive(0, 0, 0, 0, 32'h0, 0, 0);
        chk("t2_cnt_branch", bi.cnt_branch, 32'd1);
        chk("t2_cnt_taken", bi.cnt_taken, 32'd1);

        // Not-taken branch held by a two-cycle freeze.
        drive(1, 0, 0, 0, 32'h0, 0, 0);
        drive(0, 1, 1, 0, 32'h20, 0, 1);
        drive(0, 1, 1, 0, 32'h20, 0, 1);
        chk("t3_frozen_cnt", bi.cnt_branch, 32'd0);
        drive(0, 1, 1, 0, 32'h20, 0, 0);
        chk("t3_no_sel", 32'(bi.pc_sel), 32'd0);
        drive(0, 0, 0, 0, 32'h0, 0, 0);
        chk("t3_cnt_branch", bi.cnt_branch, 32'd1);
        chk("t3_cnt_taken", bi.cnt_taken, 32'd0);

        // Redirect overrides a load-use stall.
        drive(0, 1, 1, 1, 32'h10, 1, 0);
        chk("t4_pc_we", 32'(bi.pc_we), 32'd1);
        chk("t4_flushes", {30'd0, bi.flush_ifid, bi.flush_idex}, 32'd3);
        chk("t4_pc_target", 32'(bi.pc_target), 32'h10);
        drive(0, 0, 0, 0, 32'h0, 1, 0);
        chk("t4_stall_we", 32'(bi.pc_we), 32'd0);

        // Misaligned target is flagged for a single cycle.
        drive(0, 1, 1, 1, 32'h42, 0, 0);
        chk("t5_misalign", 32'(bi.misalign), 32'd1);
        chk("t5_pc_target", 32'(bi.pc_target), 32'h42);
        drive(0, 0, 0, 0, 32'h0, 0, 0);
        chk("t5_misalign_off", 32'(bi.misalign), 32'd0);

        // Reset while a redirect is pending drops it.
        drive(0, 1, 1, 1, 32'h60, 0, 1);
        drive(0, 0, 0, 0, 32'h0, 0, 1);
        chk("t6_pending", 32'(bi.redirect_busy), 32'd1);
        drive(1, 0, 0, 0, 32'h0, 0, 1);
        chk("t6_rst_busy", 32'(bi.redirect_busy), 32'd0);
        drive(0, 0, 0, 0, 32'h0, 0, 1);
        chk("t6_busy", 32'(bi.redirect_busy), 32'd0);
        chk("t6_cnt_branch", bi.cnt_branch, 32'd0);
        chk("t6_cnt_taken", bi.cnt_taken, 32'd0);
        drive(0, 0, 0, 0, 32'h0, 0, 0);
        chk("t6_no_sel", 32'(bi.pc_sel), 32'd0);

        // Sixteen redirects wrap the 4-bit counter back to zero.
        drive(1, 0, 0, 0, 32'h0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 1, 1, 32'(i * 4), 0, 0);
            drive(0, 0, 0, 0, 32'h0, 0, 0);
        end
        chk("t7_small_taken", 32'(bs.cnt_taken), 32'd0);
        chk("t7_big_taken", bi.cnt_taken, 32'd16);

        // Random traffic checked every cycle by the model.
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 99) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 1) == 1,
                  $urandom,
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
